// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary stage: state encoding and
// default payload / stall-counter widths.
package pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 16;

  // Encoding equals the number of held entries, so occ is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter.
// Ports: CLK clock, RST sync active-high clear, inc count enable,
//        cnt current value (sticks at all-ones, never wraps).
module sat_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Only reset clears the count; at all-ones further increments are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline boundary register with flush and a
// saturating backpressure counter. Usable at any datapath boundary by WIDTH.
// Ports: CLK, RST (sync active-high), flush (drop all entries),
//        in_valid/in_data/in_ready (upstream handshake),
//        out_valid/out_data/out_ready (downstream handshake),
//        occ (entries held 0..2), stall_cnt (cycles with out_valid & !out_ready).
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_stall_inc;

  // Handshake flags depend only on the state flop, so in_ready has no
  // combinational path from any input.
  assign in_ready  = (r_state == EMPTY) || (r_state == ONE);
  assign out_valid = (r_state == ONE) || (r_state == TWO);
  assign out_data  = r_main;
  assign occ       = 2'(r_state);

  assign w_in_xfer   = in_valid & in_ready;
  assign w_out_xfer  = out_valid & out_ready;
  assign w_stall_inc = out_valid & ~out_ready;

  // State and storage update; flush only moves the state, leaving stale
  // register contents that are never exposed while out_valid is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= in_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= in_data;
          end else if (w_out_xfer) begin
            r_state <= EMPTY;
          end else if (w_in_xfer) begin
            r_skid  <= in_data;
            r_state <= TWO;
          end
        end
        TWO: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_xfer) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK(CLK),
    .RST(RST),
    .inc(w_stall_inc),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;

  logic             CLK;
  logic             RST;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occ;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks;
  int n_fail;
  int exp_stall;

  pipe_stage #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occ      (occ),
    .stall_cnt(stall_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    exp_stall = 0;
  endtask

  initial begin
    int q[$];
    int next_in;
    int exp_front;
    logic exp_in_x;
    logic exp_out_x;

    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_occ",       64'(occ),       64'd0);
    check("rst_stall",     64'(stall_cnt), 64'd0);

    // Single transfer, one-cycle latency
    drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    tick();
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_data",  64'(out_data),  64'hA5A5_0001);
    check("lat_occ",       64'(occ),       64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("drain_occ",     64'(occ),       64'd0);
    check("drain_valid",   64'(out_valid), 64'd0);

    // Fill to two under backpressure, third offer refused, ordered drain
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    check("fill1_occ",  64'(occ),      64'd1);
    check("fill1_data", 64'(out_data), 64'h11);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    tick();
    check("fill2_occ",      64'(occ),       64'd2);
    check("fill2_in_ready", 64'(in_ready),  64'd0);
    check("fill2_stall",    64'(stall_cnt), 64'd1);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    tick();
    check("full_occ",   64'(occ),       64'd2);
    check("full_data",  64'(out_data),  64'h11);
    check("full_stall", 64'(stall_cnt), 64'd2);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("ord_data2", 64'(out_data), 64'h22);
    check("ord_occ1",  64'(occ),      64'd1);
    tick();
    check("ord_empty", 64'(out_valid), 64'd0);
    check("ord_ready", 64'(in_ready),  64'd1);

    // Flush from TWO with a concurrent offer that must be dropped
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    tick();
    check("prefl_occ",   64'(occ),       64'd2);
    check("prefl_stall", 64'(stall_cnt), 64'd3);
    drive(1'b1, 32'h44, 1'b0, 1'b1);
    tick();
    check("fl_occ",      64'(occ),       64'd0);
    check("fl_valid",    64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready),  64'd1);
    check("fl_stall",    64'(stall_cnt), 64'd4);
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postfl_valid", 64'(out_valid), 64'd0);
    end
    // Next real item must come through alone, not 44
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    tick();
    check("postfl_data", 64'(out_data), 64'h77);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("postfl_drain", 64'(occ), 64'd0);

    // Stall counter saturation at 15 for CNT_W=4
    do_reset();
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_stall < 15) exp_stall++;
      check("sat_stall", 64'(stall_cnt), 64'(exp_stall));
    end
    check("sat_final", 64'(stall_cnt), 64'd15);

    // Reset in TWO with stall_cnt=7
    do_reset();
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("prerst_occ",   64'(occ),       64'd2);
    check("prerst_stall", 64'(stall_cnt), 64'd7);
    RST = 1'b1;
    drive(1'b1, 32'h3, 1'b1, 1'b1);
    tick();
    RST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    check("midrst_occ",   64'(occ),       64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_stall", 64'(stall_cnt), 64'd0);
    check("midrst_data",  64'(out_data),  64'd0);
    tick();
    check("midrst_hold",  64'(out_valid), 64'd0);

    // Random handshakes against a FIFO model, 8-bit incrementing payload
    do_reset();
    q.delete();
    next_in = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'(next_in & 8'hFF), 1'($urandom_range(0, 1)), 1'b0);
      exp_in_x  = in_valid && (q.size() < 2);
      exp_out_x = out_ready && (q.size() > 0);
      if (q.size() > 0 && !out_ready && exp_stall < 15) exp_stall++;
      if (exp_out_x) exp_front = q.pop_front();
      if (exp_in_x) begin
        q.push_back(next_in & 8'hFF);
        next_in++;
      end
      tick();
      check("rnd_occ",      64'(occ),       64'(q.size()));
      check("rnd_valid",    64'(out_valid), 64'(q.size() > 0));
      check("rnd_in_ready", 64'(in_ready),  64'(q.size() < 2));
      check("rnd_stall",    64'(stall_cnt), 64'(exp_stall));
      if (q.size() > 0) check("rnd_data", 64'(out_data), 64'(q[0]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal 1..256).
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter (legal 4..32).
REQ-003 Port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  reset, synchronous and active-high.
REQ-005 Port flush  input  1  discards all held entries.
REQ-006 Port in_valid  input  1  upstream offers in_data.
REQ-007 Port in_data  input  WIDTH  upstream payload.
REQ-008 Port in_ready  output  1  stage can accept this cycle.
REQ-009 Port out_valid  output  1  out_data is valid.
REQ-010 Port out_data  output  WIDTH  downstream payload.
REQ-011 Port out_ready  input  1  downstream accepts this cycle.
REQ-012 Port occ  output  2  number of held entries, 0..2.
REQ-013 Port stall_cnt  output  CNT_W  saturating count of backpressured cycles.

Function
REQ-014 A transfer SHALL occur on an edge where valid and ready are both high on that side; no other condition moves data.
REQ-015 The stage SHALL hold a main register and a skid register, with states EMPTY (occ=0), ONE (occ=1, main full) and TWO (occ=2, both full).
REQ-016 out_valid SHALL be 1 exactly in ONE and TWO; out_data SHALL always equal the main register.
REQ-017 in_ready SHALL be 1 exactly in EMPTY and ONE and SHALL decode from state flops only, with no combinational path from out_ready, flush or in_valid.
REQ-018 In EMPTY with an input transfer: main<=in_data and the next state is ONE; without one, the state stays EMPTY.
REQ-019 In ONE with both input and output transfers: main<=in_data and the state stays ONE.
REQ-020 In ONE with an output transfer only: the next state is EMPTY.
REQ-021 In ONE with an input transfer only: skid<=in_data and the next state is TWO.
REQ-022 In ONE with neither transfer, all state is held.
REQ-023 In TWO with an output transfer: main<=skid and the next state is ONE; otherwise all state is held.
REQ-024 Latency SHALL be one cycle from input transfer to out_valid when the stage is empty; order SHALL be strictly FIFO.
REQ-025 Flush SHALL force the next state to EMPTY, overriding REQ-018..REQ-023; an input offered in the flush cycle is discarded.
REQ-026 An output transfer in the flush cycle SHALL still count as delivered.
REQ-027 Register contents after a flush are don't-care and SHALL NOT be checked while out_valid=0.
REQ-028 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, including the flush cycle.
REQ-029 stall_cnt SHALL saturate at 2^CNT_W-1 without wrap, and only reset clears it.
REQ-030 No entry is lost or duplicated under any combination of in_valid, out_ready and flush.

Reset
REQ-031 While RST=1 at an edge, the state SHALL become EMPTY and main, skid and stall_cnt SHALL become 0.
REQ-032 RST SHALL take priority over flush and over all transfers.
REQ-033 The cycle after reset SHALL present out_valid=0, out_data=0, in_ready=1, occ=0 and stall_cnt=0.
REQ-034 Reset asserted mid-operation, in ONE or TWO, SHALL discard all entries with no output transfer reported.

Structure
REQ-035 Package pipe_pkg SHALL hold the state enumeration (EMPTY, ONE, TWO) and the default WIDTH and CNT_W constants.
REQ-036 The saturating counter SHALL be the sub-module sat_cnt, parameterised by CNT_W, with inputs CLK, RST and inc.
REQ-037 pipe_stage SHALL be usable as the IF/ID, ID/EX, EX/MEM or MEM/WB boundary of the pipelined datapath by setting WIDTH.

Verification
REQ-038 Reset then in_data=32'hA5A5_0001 with in_valid=1 and out_ready=1 -> out_valid=1 and out_data=32'hA5A5_0001 next cycle; occ=1.
REQ-039 out_ready=0, push 32'h11 then 32'h22 -> occ=2 and in_ready=0; a third offer (32'h33) is not accepted; with out_ready=1, 32'h11 then 32'h22 exit in order.
REQ-040 occ=2, then flush=1 for one cycle with in_valid=1 (32'h44) -> occ=0, out_valid=0 and in_ready=1 next cycle; 32'h44 never appears.
REQ-041 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds at 15.
REQ-042 RST=1 in state TWO with stall_cnt=7 -> occ=0, out_valid=0 and stall_cnt=0 next cycle.
REQ-043 Random in_valid/out_ready at 50% each for 10,000 cycles, WIDTH=8 incrementing data -> output sequence equals input sequence, with no gaps or repeats.
